// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: FSM state encoding and
// iteration counts used by the sequential divider (and the multiplier).
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam int DIV_ITERS = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left, bring in
// the next dividend bit, and keep the trial difference only if it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // One extra guard bit so the trial difference's sign is never ambiguous.
  always_comb begin
    shifted = {rem_in, dividend_msb};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider with MIPS div semantics: one quotient bit per cycle
// on operand magnitudes, followed by a sign-correction cycle.
module seq_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             div_by_zero,
  output logic             busy
);

  mdu_state_t state, next_state;

  logic [5:0]       count;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] div_mag;
  logic [WIDTH:0]   part_rem;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  // The most-negative dividend maps to 2^(WIDTH-1), which still fits unsigned.
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;
  assign b_zero = (b == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (part_rem),
    .dividend_msb (work_q[WIDTH-1]),
    .divisor      (div_mag),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = b_zero ? DONE : RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN:     if (count == 6'(DIV_ITERS - 1)) next_state = FIX;
      FIX:     next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // The dividend register doubles as the quotient shift register: one bit
  // leaves at the top into the remainder while the new quotient bit enters below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      work_q      <= '0;
      div_mag     <= '0;
      part_rem    <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= (next_state == DONE);
      busy <= (next_state == RUN) || (next_state == FIX);
      if (accept) begin
        if (b_zero) begin
          quotient    <= '0;
          remainder   <= '0;
          div_by_zero <= 1'b1;
        end else begin
          work_q      <= a_mag;
          div_mag     <= b_mag;
          part_rem    <= '0;
          count       <= '0;
          neg_q       <= a[WIDTH-1] ^ b[WIDTH-1];
          neg_r       <= a[WIDTH-1];
          div_by_zero <= 1'b0;
        end
      end else if (state == RUN) begin
        part_rem <= step_rem;
        work_q   <= {work_q[WIDTH-2:0], step_q};
        count    <= count + 6'd1;
      end else if (state == FIX) begin
        quotient  <= neg_q ? -work_q : work_q;
        remainder <= neg_r ? -part_rem[WIDTH-1:0] : part_rem[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients/remainders, cycle
// timing of busy/done, divide-by-zero, ignored restarts and mid-operation reset.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        div_by_zero;
  logic        busy;

  int n_compared;
  int n_mismatched;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .a           (a),
    .b           (b),
    .start       (start),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
  endtask

  // Starts a division in the current cycle (cycle 0), follows it to done and
  // returns in the done cycle; poke >= 0 fires a stray start in that cycle.
  task automatic runDivide(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input int poke);
    int cyc;
    int busy_low;
    applyStimulus(av, bv);
    step();
    start    = 1'b0;
    cyc      = 1;
    busy_low = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) busy_low++;
      if (cyc == poke) applyStimulus(32'd1, 32'd1);
      step();
      start = 1'b0;
      cyc++;
    end
    checkOutput({tag, " done_cycle"}, 32'(cyc), 32'd34);
    checkOutput({tag, " busy_gaps"}, 32'(busy_low), 32'd0);
    checkOutput({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " q"}, quotient, exp_q);
    checkOutput({tag, " r"}, remainder, exp_r);
    checkOutput({tag, " dbz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset = 1'b0;
    a     = '0;
    b     = '0;
    start = 1'b0;
    step();
    step();
    checkOutput("reset q", quotient, 32'd0);
    checkOutput("reset r", remainder, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset dbz", {31'd0, div_by_zero}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    step();

    $display("[TB] 100 / 7 with stray start in cycle 10");
    runDivide("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 10);
    step();
    checkOutput("100/7 done_pulse", {31'd0, done}, 32'd0);
    checkOutput("100/7 q_hold", quotient, 32'd14);
    step();

    $display("[TB] signed cases, back-to-back");
    runDivide("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);
    runDivide("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, -1);
    step();
    runDivide("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, -1);
    step();

    $display("[TB] divide by zero");
    applyStimulus(32'd5, 32'd0);
    step();
    start = 1'b0;
    checkOutput("5/0 done", {31'd0, done}, 32'd1);
    checkOutput("5/0 dbz", {31'd0, div_by_zero}, 32'd1);
    checkOutput("5/0 busy", {31'd0, busy}, 32'd0);
    checkOutput("5/0 q", quotient, 32'd0);
    checkOutput("5/0 r", remainder, 32'd0);
    step();
    checkOutput("5/0 done_pulse", {31'd0, done}, 32'd0);
    checkOutput("5/0 dbz_hold", {31'd0, div_by_zero}, 32'd1);
    runDivide("9/3", 32'd9, 32'd3, 32'd3, 32'd0, -1);
    step();

    $display("[TB] reset during a division");
    applyStimulus(32'd1000, 32'd3);
    step();
    start = 1'b0;
    repeat (14) step();
    checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid-reset q", quotient, 32'd0);
    checkOutput("mid-reset busy", {31'd0, busy}, 32'd0);
    checkOutput("mid-reset done", {31'd0, done}, 32'd0);
    checkOutput("mid-reset r", remainder, 32'd0);
    step();
    step();
    reset = 1'b1;
    runDivide("20/6", 32'd20, 32'd6, 32'd3, 32'd2, -1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential signed 32-bit divider for the multi-cycle MIPS datapath. It sits between the A/B operand registers and the HI/LO register pair. On `start` it computes quotient and remainder in MIPS `div` semantics, one quotient bit per cycle. It reports completion and divide-by-zero to the control FSM and to the exception unit. Quotient feeds LO and remainder feeds HI.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Only 32 is verified.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `a` input WIDTH: dividend, two's complement; sampled only on an accepted `start`.
- `b` input WIDTH: divisor, two's complement; sampled only on an accepted `start`.
- `start` input 1: request a division; level-sampled each cycle.
- `quotient` output WIDTH: signed quotient, truncated toward zero.
- `remainder` output WIDTH: signed remainder, same sign as the dividend.
- `done` output 1: one-cycle pulse; results are valid from this cycle on.
- `div_by_zero` output 1: set with `done` when `b` was 0; held until the next accepted `start`.
- `busy` output 1: high while a division is in progress.

## Operation
- States:
  - IDLE: waiting.
  - RUN: 32 iterations, 6-bit counter 0..31.
  - FIX: sign correction.
  - DONE: completion cycle.
- Accepting a start:
  - `start` is accepted in IDLE or DONE only.
  - `start` in RUN or FIX is ignored; the operation in flight is not disturbed.
- Accepted start with `b == 0`:
  - Go to DONE.
  - `quotient = 0`, `remainder = 0`, `div_by_zero = 1`.
- Accepted start with `b != 0`:
  - Latch `|a|` and `|b|` as unsigned WIDTH-bit magnitudes, plus both sign bits.
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
  - Clear `div_by_zero`.
  - Go to RUN.
- RUN, one restoring step per cycle:
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Trial-subtract `|b|`.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After counter value 31, go to FIX.
- FIX:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if `a` was negative.
  - Go to DONE.
- DONE:
  - `done` is high for exactly one cycle.
  - Next state is IDLE, or RUN / DONE again if `start` is high.
- Results:
  - `quotient` and `remainder` change only in FIX or on an accepted divide-by-zero start.
  - Otherwise they hold their last value indefinitely.
- `0x80000000 / -1`:
  - Magnitude 2^31 fits the unsigned path; negation wraps.
  - Result is `q = 0x80000000`, `r = 0`. No overflow flag.

## Timing
- Reset values:
  - All outputs are 0; state is IDLE; all internal registers are 0.
  - Assertion of `reset` in any state takes effect immediately and abandons the operation.
  - After deassertion the block accepts `start` on the next rising edge.
- Normal division, `start` in cycle 0:
  - `busy` is high in cycles 1–33 (RUN is cycles 1–32, FIX is cycle 33).
  - `done` is high in cycle 34.
- Divide by zero, `start` in cycle 0:
  - `done = 1` and `div_by_zero = 1` in cycle 1.
  - `busy` stays 0.
- Back-to-back:
  - `start` high in the DONE cycle begins the next operation.
  - That operation's `done` comes 34 cycles later.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `mdu_pkg`:
  - State encoding localparams: IDLE, RUN, FIX, DONE.
  - `DIV_ITERS = 32`.
  - The multiplier reuses the same package.
- Sub-module `div_step`:
  - Combinational, one restoring iteration.
  - Inputs: partial remainder, dividend MSB, divisor magnitude.
  - Outputs: next remainder, quotient bit.
- The top level holds the FSM, counter, operand and sign registers, and the negation logic.

## Test plan
- 100 / 7, start in cycle 0 -> `done` in cycle 34, `q = 14`, `r = 2`, `busy` high in cycles 1–33.
- -7 / 2 -> `q = 0xFFFFFFFD` (-3), `r = 0xFFFFFFFF` (-1). 7 / -2 -> `q = -3`, `r = 1`.
- `0x80000000 / 0xFFFFFFFF` -> `q = 0x80000000`, `r = 0`, `div_by_zero = 0`.
- 5 / 0 -> `done` and `div_by_zero` high in cycle 1, `q = r = 0`. A following 9 / 3 clears `div_by_zero` and gives `q = 3`, `r = 0`.
- `start` pulsed again in cycle 10 with `a = 1`, `b = 1` during 100 / 7 -> ignored; the result is still 14 / 2 in cycle 34.
- `reset` asserted in cycle 15 of a division -> outputs 0 and state IDLE immediately. After release, 20 / 6 gives `q = 3`, `r = 2` 34 cycles after its start.
